// File: rtl/register_rename_unit.sv
`default_nettype none
// =============================================================================
// register_rename_unit : architectural-to-physical map plus circular free list
// Revision: 1.0
// =============================================================================
module register_rename_unit #(
  parameter int PHY_REGS  = 256,
  parameter int TAG_W     = 8,
  parameter int ARCH_REGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_valid,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  input  logic             rd_write,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_free_phy,
  input  logic             exception,
  input  logic             mret_sig,
  output logic [TAG_W-1:0] Operand1_phy,
  output logic [TAG_W-1:0] Operand2_phy,
  output logic [TAG_W-1:0] Rd_phy,
  output logic [TAG_W-1:0] Old_Rd_phy,
  output logic             rename_valid,
  output logic             stall,
  output logic [TAG_W:0]   free_count
);

  localparam logic [TAG_W:0]   C_FULL       = (TAG_W+1)'(PHY_REGS);
  localparam logic [TAG_W:0]   C_INIT_COUNT = (TAG_W+1)'(PHY_REGS - ARCH_REGS);
  localparam logic [TAG_W-1:0] C_INIT_TAIL  = TAG_W'(PHY_REGS - ARCH_REGS);

  logic [TAG_W-1:0] map_q [ARCH_REGS];
  logic [TAG_W-1:0] fl_q  [PHY_REGS];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic [TAG_W-1:0] op1_q, op1_d;
  logic [TAG_W-1:0] op2_q, op2_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic [TAG_W-1:0] old_q, old_d;
  logic             valid_q, valid_d;

  logic             w_acc;
  logic             w_alloc;
  logic             w_rel;
  logic             w_flush;
  logic [TAG_W-1:0] w_new_tag;

  assign stall     = (count_q == '0);
  assign w_flush   = exception | mret_sig;
  assign w_acc     = inst_valid & ~stall;
  assign w_alloc   = w_acc & rd_write & (rd != 5'd0);
  assign w_rel     = commit_valid & (commit_free_phy != '0) & (count_q != C_FULL);
  assign w_new_tag = fl_q[head_q];

  // Sources see the map as it stood before this cycle's allocation.
  always_comb begin
    valid_d = w_acc;
    op1_d   = (w_acc && rs1 != 5'd0) ? map_q[rs1] : '0;
    op2_d   = (w_acc && rs2 != 5'd0) ? map_q[rs2] : '0;
    rd_d    = w_alloc ? w_new_tag : '0;
    old_d   = w_alloc ? map_q[rd] : '0;
    head_d  = w_alloc ? head_q + TAG_W'(1) : head_q;
    tail_d  = w_rel   ? tail_q + TAG_W'(1) : tail_q;
    count_d = count_q;
    case ({w_alloc, w_rel})
      2'b10:   count_d = count_q - (TAG_W+1)'(1);
      2'b01:   count_d = count_q + (TAG_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Recovery rebuilds exactly the reset picture: identity map, tags 32.. free.
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i] <= TAG_W'(i);
      end
      for (int k = 0; k < PHY_REGS; k++) begin
        fl_q[k] <= (k < PHY_REGS - ARCH_REGS) ? TAG_W'(ARCH_REGS + k) : '0;
      end
      head_q  <= '0;
      tail_q  <= C_INIT_TAIL;
      count_q <= C_INIT_COUNT;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      old_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (w_alloc) begin
        map_q[rd] <= w_new_tag;
      end
      if (w_rel) begin
        fl_q[tail_q] <= commit_free_phy;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= rd_d;
      old_q   <= old_d;
      valid_q <= valid_d;
    end
  end

  assign Operand1_phy = op1_q;
  assign Operand2_phy = op2_q;
  assign Rd_phy       = rd_q;
  assign Old_Rd_phy   = old_q;
  assign rename_valid = valid_q;
  assign free_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_register_rename_unit.sv
`default_nettype none
// =============================================================================
// tb_register_rename_unit : directed and randomized checks against a queue model
// Revision: 1.0
// =============================================================================
module tb_register_rename_unit;

  localparam int PHY  = 256;
  localparam int ARCH = 32;

  logic       clk;
  logic       reset;
  logic       inst_valid;
  logic [4:0] rs1, rs2, rd;
  logic       rd_write;
  logic       commit_valid;
  logic [7:0] commit_free_phy;
  logic       exception, mret_sig;
  logic [7:0] Operand1_phy, Operand2_phy, Rd_phy, Old_Rd_phy;
  logic       rename_valid, stall;
  logic [8:0] free_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural map and an ordered queue of free tags.
  int map_m [ARCH];
  int fq [$];
  int exp_valid, exp_op1, exp_op2, exp_rd, exp_old, exp_w, exp_cnt;

  register_rename_unit #(.PHY_REGS(PHY), .TAG_W(8), .ARCH_REGS(ARCH)) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rd_write(rd_write),
    .commit_valid(commit_valid), .commit_free_phy(commit_free_phy),
    .exception(exception), .mret_sig(mret_sig),
    .Operand1_phy(Operand1_phy), .Operand2_phy(Operand2_phy),
    .Rd_phy(Rd_phy), .Old_Rd_phy(Old_Rd_phy),
    .rename_valid(rename_valid), .stall(stall), .free_count(free_count)
  );

  always #5 clk = ~clk;

  task automatic model_init();
    for (int i = 0; i < ARCH; i++) map_m[i] = i;
    fq.delete();
    for (int t = ARCH; t < PHY; t++) fq.push_back(t);
  endtask

  task automatic idle();
    inst_valid = 0; rs1 = 0; rs2 = 0; rd = 0; rd_write = 0;
    commit_valid = 0; commit_free_phy = 0; exception = 0; mret_sig = 0;
  endtask

  task automatic set_inst(input int r1, input int r2, input int d, input int w);
    inst_valid = 1; rs1 = 5'(r1); rs2 = 5'(r2); rd = 5'(d); rd_write = w[0];
  endtask

  // Advance one clock, predicting outputs from the model state before the edge.
  task automatic tick();
    int  tag;
    bit  acc, rel_ok;
    if (reset || exception || mret_sig) begin
      model_init();
      exp_valid = 0; exp_op1 = 0; exp_op2 = 0; exp_rd = 0; exp_old = 0; exp_w = 0;
    end else begin
      acc    = inst_valid && (fq.size() != 0);
      rel_ok = commit_valid && (commit_free_phy != 0) && (fq.size() != PHY);
      exp_valid = acc;
      exp_op1 = (acc && rs1 != 0) ? map_m[rs1] : 0;
      exp_op2 = (acc && rs2 != 0) ? map_m[rs2] : 0;
      exp_w   = acc && rd_write;
      exp_rd  = 0;
      exp_old = exp_w ? map_m[rd] : 0;
      if (exp_w && rd != 0) begin
        tag = fq.pop_front();
        exp_rd = tag;
        map_m[rd] = tag;
      end
      if (rel_ok) fq.push_back(int'(commit_free_phy));
    end
    exp_cnt = fq.size();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rename_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d want=0", rename_valid); end
    checks++; if (Rd_phy !== 8'd0 || Operand1_phy !== 8'd0 || Operand2_phy !== 8'd0 || Old_Rd_phy !== 8'd0) begin
      failures++; $display("FAIL reset_tags got=%0d/%0d/%0d/%0d want=0", Operand1_phy, Operand2_phy, Rd_phy, Old_Rd_phy); end
    checks++; if (free_count !== 9'd224) begin failures++; $display("FAIL reset_count got=%0d want=224", free_count); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0d want=0", stall); end
  endtask

  task automatic test_basic();
    do_reset();
    set_inst(1, 2, 3, 1);
    tick();
    idle();
    checks++; if (rename_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0d want=1", rename_valid); end
    checks++; if (Operand1_phy !== 8'd1 || Operand2_phy !== 8'd2) begin
      failures++; $display("FAIL basic_src got=%0d/%0d want=1/2", Operand1_phy, Operand2_phy); end
    checks++; if (Rd_phy !== 8'd32 || Old_Rd_phy !== 8'd3) begin
      failures++; $display("FAIL basic_dst got=%0d/%0d want=32/3", Rd_phy, Old_Rd_phy); end
    checks++; if (free_count !== 9'd223) begin failures++; $display("FAIL basic_count got=%0d want=223", free_count); end
    tick();
    checks++; if (rename_valid !== 1'b0 || Rd_phy !== 8'd0) begin
      failures++; $display("FAIL idle_after got=%0d/%0d want=0/0", rename_valid, Rd_phy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_inst(0, 0, 3, 1);
    tick();
    set_inst(3, 0, 3, 1);
    tick();
    idle();
    checks++; if (Operand1_phy !== 8'd32 || Rd_phy !== 8'd33 || Old_Rd_phy !== 8'd32) begin
      failures++; $display("FAIL b2b got=%0d/%0d/%0d want=32/33/32", Operand1_phy, Rd_phy, Old_Rd_phy); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    set_inst(0, 7, 0, 1);
    tick();
    idle();
    checks++; if (rename_valid !== 1'b1 || Rd_phy !== 8'd0 || Operand1_phy !== 8'd0 || Operand2_phy !== 8'd7) begin
      failures++; $display("FAIL rd_zero got=v%0d rd%0d s%0d/%0d want=v1 rd0 s0/7", rename_valid, Rd_phy, Operand1_phy, Operand2_phy); end
    checks++; if (free_count !== 9'd224) begin failures++; $display("FAIL rd_zero_count got=%0d want=224", free_count); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 224; i++) begin
      set_inst($urandom_range(0, 31), $urandom_range(0, 31), (i % 31) + 1, 1);
      tick();
      checks++; if (Rd_phy !== 8'(32 + i)) begin failures++; $display("FAIL fill_tag[%0d] got=%0d want=%0d", i, Rd_phy, 32 + i); end
    end
    checks++; if (stall !== 1'b1 || free_count !== 9'd0) begin
      failures++; $display("FAIL empty got=stall%0d cnt%0d want=stall1 cnt0", stall, free_count); end
    set_inst(1, 2, 4, 1);
    commit_valid = 1; commit_free_phy = 8'd5;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL no_bypass_stall got=%0d want=1", stall); end
    tick();
    commit_valid = 0;
    checks++; if (rename_valid !== 1'b0 || Rd_phy !== 8'd0) begin
      failures++; $display("FAIL stalled_inst got=v%0d rd%0d want=v0 rd0", rename_valid, Rd_phy); end
    checks++; if (free_count !== 9'd1 || stall !== 1'b0) begin
      failures++; $display("FAIL refill got=cnt%0d stall%0d want=cnt1 stall0", free_count, stall); end
    tick();
    idle();
    checks++; if (Rd_phy !== 8'd5 || rename_valid !== 1'b1) begin
      failures++; $display("FAIL realloc got=rd%0d v%0d want=rd5 v1", Rd_phy, rename_valid); end
  endtask

  task automatic test_simul_and_wrap();
    do_reset();
    for (int i = 0; i < 214; i++) begin
      set_inst(0, 0, (i % 31) + 1, 1);
      tick();
    end
    checks++; if (free_count !== 9'd10) begin failures++; $display("FAIL pre_simul_count got=%0d want=10", free_count); end
    set_inst(0, 0, 9, 1);
    commit_valid = 1; commit_free_phy = 8'd3;
    tick();
    checks++; if (free_count !== 9'd10 || Rd_phy !== 8'd246) begin
      failures++; $display("FAIL simul got=cnt%0d rd%0d want=cnt10 rd246", free_count, Rd_phy); end
    // 300 more paired alloc/release cycles drive both pointers past the wrap.
    for (int i = 0; i < 300; i++) begin
      set_inst($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 31), 1);
      commit_valid = 1; commit_free_phy = 8'($urandom_range(1, 255));
      tick();
      checks++; if (Rd_phy !== 8'(exp_rd) || free_count !== 9'd10) begin
        failures++; $display("FAIL wrap[%0d] got=rd%0d cnt%0d want=rd%0d cnt10", i, Rd_phy, free_count, exp_rd); end
    end
    idle();
  endtask

  task automatic test_exception();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_inst(0, 0, 3, 1);
      tick();
    end
    set_inst(3, 3, 3, 1);
    commit_valid = 1; commit_free_phy = 8'd40;
    exception = 1;
    tick();
    idle();
    checks++; if (rename_valid !== 1'b0 || Rd_phy !== 8'd0 || Operand1_phy !== 8'd0 || Old_Rd_phy !== 8'd0) begin
      failures++; $display("FAIL exc_flush got=v%0d rd%0d s%0d o%0d want=0", rename_valid, Rd_phy, Operand1_phy, Old_Rd_phy); end
    checks++; if (free_count !== 9'd224) begin failures++; $display("FAIL exc_count got=%0d want=224", free_count); end
    set_inst(3, 0, 0, 0);
    tick();
    checks++; if (Operand1_phy !== 8'd3) begin failures++; $display("FAIL exc_map got=%0d want=3", Operand1_phy); end
    set_inst(0, 0, 7, 1);
    tick();
    checks++; if (Rd_phy !== 8'd32) begin failures++; $display("FAIL exc_alloc got=%0d want=32", Rd_phy); end
    set_inst(0, 0, 8, 1);
    mret_sig = 1;
    tick();
    idle();
    checks++; if (rename_valid !== 1'b0 || free_count !== 9'd224) begin
      failures++; $display("FAIL mret got=v%0d cnt%0d want=v0 cnt224", rename_valid, free_count); end
    set_inst(7, 0, 7, 1);
    tick();
    idle();
    checks++; if (Operand1_phy !== 8'd7 || Rd_phy !== 8'd32) begin
      failures++; $display("FAIL mret_resume got=s%0d rd%0d want=s7 rd32", Operand1_phy, Rd_phy); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      inst_valid      = ($urandom_range(0, 99) < 80);
      rs1             = 5'($urandom);
      rs2             = 5'($urandom);
      rd              = 5'($urandom);
      rd_write        = ($urandom_range(0, 99) < 75);
      commit_valid    = ($urandom_range(0, 99) < 35);
      commit_free_phy = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom);
      exception       = ($urandom_range(0, 299) == 0);
      mret_sig        = ($urandom_range(0, 399) == 0);
      #1;
      checks++; if (stall !== (fq.size() == 0)) begin
        failures++; $display("FAIL rnd_stall[%0d] got=%0d want=%0d", n, stall, fq.size() == 0); end
      tick();
      checks++; if (rename_valid !== exp_valid[0] || Operand1_phy !== 8'(exp_op1) || Operand2_phy !== 8'(exp_op2)) begin
        failures++; $display("FAIL rnd_src[%0d] got=v%0d %0d/%0d want=v%0d %0d/%0d", n, rename_valid,
                             Operand1_phy, Operand2_phy, exp_valid, exp_op1, exp_op2); end
      checks++; if (Rd_phy !== 8'(exp_rd) || free_count !== 9'(exp_cnt)) begin
        failures++; $display("FAIL rnd_dst[%0d] got=rd%0d cnt%0d want=rd%0d cnt%0d", n, Rd_phy, free_count, exp_rd, exp_cnt); end
      if (exp_w != 0) begin
        checks++; if (Old_Rd_phy !== 8'(exp_old)) begin
          failures++; $display("FAIL rnd_old[%0d] got=%0d want=%0d", n, Old_Rd_phy, exp_old); end
      end
    end
    idle();
  endtask

  initial begin
    clk = 0;
    idle();
    reset = 1;
    model_init();
    test_reset();
    test_basic();
    test_back_to_back();
    test_rd_zero();
    test_stall();
    test_simul_and_wrap();
    test_exception();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
